// File: rtl/placement_pkg.sv
//------------------------------------------------------------------------------
// placement_pkg: shared constants and state encoding for placement_checker
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package placement_pkg;

  localparam int EMPTY      = -1;
  localparam int DEF_N      = 6;
  localparam int DEF_N_EDGE = 32;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_RANGE    = 3'd1;
  localparam logic [2:0] ERR_POS      = 3'd2;
  localparam logic [2:0] ERR_UNPLACED = 3'd3;
  localparam logic [2:0] ERR_SHARED   = 3'd4;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    G_REQ  = 4'd1,
    G_DATA = 4'd2,
    G_POS  = 4'd3,
    E_REQ  = 4'd4,
    E_DATA = 4'd5,
    E_PA   = 4'd6,
    E_PB   = 4'd7,
    E_ACC  = 4'd8,
    FIN    = 4'd9
  } state_t;

endpackage

`default_nettype wire

// File: rtl/placement_checker_if.sv
//------------------------------------------------------------------------------
// placement_checker_if: control, status and memory read ports of the checker
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface placement_checker_if #(
  parameter int DW = 32
);
  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [2:0]           err_code;
  logic signed [DW-1:0] err_idx;
  logic signed [DW-1:0] cost;
  logic signed [DW-1:0] cost_1hop;

  logic                 reEA, reEB, rePX, rePY, reGrid;
  logic signed [DW-1:0] addrEA, addrEB, addrPX, addrPY, addrGrid;
  logic signed [DW-1:0] doutEA, doutEB, doutPX, doutPY, doutGrid;

  modport slave (
    input  start, doutEA, doutEB, doutPX, doutPY, doutGrid,
    output busy, done, pass, err_code, err_idx, cost, cost_1hop,
    output reEA, reEB, rePX, rePY, reGrid,
    output addrEA, addrEB, addrPX, addrPY, addrGrid
  );

  modport master (
    output start, doutEA, doutEB, doutPX, doutPY, doutGrid,
    input  busy, done, pass, err_code, err_idx, cost, cost_1hop,
    input  reEA, reEB, rePX, rePY, reGrid,
    input  addrEA, addrEB, addrPX, addrPY, addrGrid
  );

endinterface

`default_nettype wire

// File: rtl/abs_half.sv
//------------------------------------------------------------------------------
// abs_half: |x-y| and ceil(|x-y|/2) for one axis, purely combinational
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module abs_half #(
  parameter int DW = 32
) (
  input  logic signed [DW-1:0] x,
  input  logic signed [DW-1:0] y,
  output logic signed [DW-1:0] diff,
  output logic signed [DW-1:0] half
);

  localparam logic signed [DW-1:0] c_one = DW'(1);

  logic signed [DW-1:0] w_d;

  always_comb begin
    w_d  = x - y;
    diff = w_d[DW-1] ? -w_d : w_d;
    half = (diff + c_one) >>> 1;
  end

endmodule

`default_nettype wire

// File: rtl/placement_checker.sv
//------------------------------------------------------------------------------
// placement_checker: validates grid/position consistency and edge wirelength
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module placement_checker
  import placement_pkg::*;
#(
  parameter int N       = DEF_N,
  parameter int N_NODES = DEF_N * DEF_N,
  parameter int N_EDGE  = DEF_N_EDGE,
  parameter int DW      = 32
) (
  input  logic              clk,
  input  logic              reset,
  placement_checker_if.slave bus
);

  localparam logic signed [DW-1:0] c_empty     = DW'(EMPTY);
  localparam logic signed [DW-1:0] c_one       = DW'(1);
  localparam logic signed [DW-1:0] c_n         = DW'(N);
  localparam logic signed [DW-1:0] c_n_nodes   = DW'(N_NODES);
  localparam logic signed [DW-1:0] c_last_cell = DW'(N * N - 1);
  localparam logic signed [DW-1:0] c_last_edge = DW'(N_EDGE - 1);

  state_t r_state, w_next;

  logic signed [DW-1:0] r_g, r_e, r_b, r_ax, r_ay, r_dsum, r_hsum;
  logic signed [DW-1:0] r_cost, r_cost_1hop, r_err_idx;
  logic [2:0]           r_err_code, w_err;
  logic                 r_pass, w_g_adv;
  logic signed [DW-1:0] w_dx, w_dy, w_hx, w_hy, w_cell;

  function automatic logic id_bad(input logic signed [DW-1:0] v);
    return (v < 0) || (v >= c_n_nodes);
  endfunction

  // Point b's position arrives on the PX/PY data ports during E_PB.
  abs_half #(.DW(DW)) u_abs_x (.x(r_ax), .y(bus.doutPX), .diff(w_dx), .half(w_hx));
  abs_half #(.DW(DW)) u_abs_y (.x(r_ay), .y(bus.doutPY), .diff(w_dy), .half(w_hy));

  assign w_cell = bus.doutPX * c_n + bus.doutPY;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    w_err         = ERR_NONE;
    w_g_adv       = 1'b0;
    bus.reGrid    = 1'b0;
    bus.addrGrid  = '0;
    bus.reEA      = 1'b0;
    bus.addrEA    = '0;
    bus.reEB      = 1'b0;
    bus.addrEB    = '0;
    bus.rePX      = 1'b0;
    bus.addrPX    = '0;
    bus.rePY      = 1'b0;
    bus.addrPY    = '0;
    case (r_state)
      IDLE: if (bus.start) w_next = G_REQ;
      G_REQ: begin
        bus.reGrid   = 1'b1;
        bus.addrGrid = r_g;
        w_next       = G_DATA;
      end
      G_DATA: begin
        if (bus.doutGrid == c_empty) begin
          w_g_adv = 1'b1;
          w_next  = (r_g == c_last_cell) ? E_REQ : G_REQ;
        end else if (id_bad(bus.doutGrid)) begin
          w_err  = ERR_RANGE;
          w_next = FIN;
        end else begin
          bus.rePX   = 1'b1;
          bus.addrPX = bus.doutGrid;
          bus.rePY   = 1'b1;
          bus.addrPY = bus.doutGrid;
          w_next     = G_POS;
        end
      end
      G_POS: begin
        if (w_cell != r_g) begin
          w_err  = ERR_POS;
          w_next = FIN;
        end else begin
          w_g_adv = 1'b1;
          w_next  = (r_g == c_last_cell) ? E_REQ : G_REQ;
        end
      end
      E_REQ: begin
        bus.reEA   = 1'b1;
        bus.addrEA = r_e;
        bus.reEB   = 1'b1;
        bus.addrEB = r_e;
        w_next     = E_DATA;
      end
      E_DATA: begin
        if (id_bad(bus.doutEA) || id_bad(bus.doutEB)) begin
          w_err  = ERR_RANGE;
          w_next = FIN;
        end else begin
          bus.rePX   = 1'b1;
          bus.addrPX = bus.doutEA;
          bus.rePY   = 1'b1;
          bus.addrPY = bus.doutEA;
          w_next     = E_PA;
        end
      end
      E_PA: begin
        bus.rePX   = 1'b1;
        bus.addrPX = r_b;
        bus.rePY   = 1'b1;
        bus.addrPY = r_b;
        w_next     = E_PB;
      end
      E_PB: begin
        if ((r_ax == c_empty) || (r_ay == c_empty) ||
            (bus.doutPX == c_empty) || (bus.doutPY == c_empty)) begin
          w_err  = ERR_UNPLACED;
          w_next = FIN;
        end else if ((w_dx + w_dy) == '0) begin
          w_err  = ERR_SHARED;
          w_next = FIN;
        end else begin
          w_next = E_ACC;
        end
      end
      E_ACC:   w_next = (r_e == c_last_edge) ? FIN : E_REQ;
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_g         <= '0;
      r_e         <= '0;
      r_b         <= '0;
      r_ax        <= '0;
      r_ay        <= '0;
      r_dsum      <= '0;
      r_hsum      <= '0;
      r_cost      <= '0;
      r_cost_1hop <= '0;
      r_err_code  <= ERR_NONE;
      r_err_idx   <= '0;
      r_pass      <= 1'b0;
    end else begin
      if (r_state == IDLE && bus.start) begin
        r_g         <= '0;
        r_e         <= '0;
        r_cost      <= '0;
        r_cost_1hop <= '0;
        r_err_code  <= ERR_NONE;
        r_err_idx   <= '0;
        r_pass      <= 1'b0;
      end
      if (w_g_adv) r_g <= r_g + c_one;
      if (r_state == E_DATA) r_b <= bus.doutEB;
      if (r_state == E_PA) begin
        r_ax <= bus.doutPX;
        r_ay <= bus.doutPY;
      end
      if (r_state == E_PB) begin
        r_dsum <= w_dx + w_dy;
        r_hsum <= w_hx + w_hy;
      end
      if (r_state == E_ACC) begin
        r_cost      <= r_cost + r_dsum - c_one;
        r_cost_1hop <= r_cost_1hop + r_hsum - c_one;
        r_e         <= r_e + c_one;
      end
      // Every error jumps straight to FIN, so the first error is the only one.
      if (w_err != ERR_NONE) begin
        r_err_code <= w_err;
        r_err_idx  <= (r_state == G_DATA || r_state == G_POS) ? r_g : r_e;
      end
      if (w_next == FIN && r_state != FIN) r_pass <= (w_err == ERR_NONE);
    end
  end

  assign bus.busy      = (r_state != IDLE) && (r_state != FIN);
  assign bus.done      = (r_state == FIN);
  assign bus.pass      = r_pass;
  assign bus.err_code  = r_err_code;
  assign bus.err_idx   = r_err_idx;
  assign bus.cost      = r_cost;
  assign bus.cost_1hop = r_cost_1hop;

endmodule

`default_nettype wire

// File: tb/tb_placement_checker.sv
//------------------------------------------------------------------------------
// tb_placement_checker: scoreboard bench for placement_checker (N=6, 32 edges)
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_placement_checker;
  import placement_pkg::*;

  localparam int N     = 6;
  localparam int NN    = 36;
  localparam int NE    = 32;
  localparam int CELLS = N * N;

  logic clk = 1'b0;
  logic reset = 1'b0;

  placement_checker_if #(.DW(32)) bus ();

  placement_checker #(.N(N), .N_NODES(NN), .N_EDGE(NE), .DW(32)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int grid[CELLS];
  int px[NN];
  int py[NN];
  int ea[NE];
  int eb[NE];

  // Synchronous-read memories: data appears the cycle after re.
  always @(posedge clk) begin
    if (bus.reGrid) bus.doutGrid <= grid[bus.addrGrid[5:0]];
    if (bus.reEA)   bus.doutEA   <= ea[bus.addrEA[4:0]];
    if (bus.reEB)   bus.doutEB   <= eb[bus.addrEB[4:0]];
    if (bus.rePX)   bus.doutPX   <= px[bus.addrPX[5:0]];
    if (bus.rePY)   bus.doutPY   <= py[bus.addrPY[5:0]];
  end

  typedef struct {
    bit       pass;
    logic [2:0] code;
    int       idx;
    int       cost;
    int       cost1;
    int       cyc;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference walk: results plus the cycle at which done is seen after start.
  function automatic exp_t model();
    exp_t r;
    int t, v, a, b, dx, dy;
    r.pass = 1'b1; r.code = 3'd0; r.idx = 0; r.cost = 0; r.cost1 = 0; r.cyc = 0;
    t = 0;
    for (int g = 0; g < CELLS; g++) begin
      v = grid[g];
      t += 2;
      if (v == -1) continue;
      if (v < 0 || v >= NN) begin r.pass = 0; r.code = 3'd1; r.idx = g; r.cyc = t + 1; return r; end
      t += 1;
      if (px[v] * N + py[v] != g) begin r.pass = 0; r.code = 3'd2; r.idx = g; r.cyc = t + 1; return r; end
    end
    for (int e = 0; e < NE; e++) begin
      a = ea[e]; b = eb[e];
      t += 2;
      if (a < 0 || a >= NN || b < 0 || b >= NN) begin r.pass = 0; r.code = 3'd1; r.idx = e; r.cyc = t + 1; return r; end
      t += 2;
      if (px[a] == -1 || py[a] == -1 || px[b] == -1 || py[b] == -1) begin
        r.pass = 0; r.code = 3'd3; r.idx = e; r.cyc = t + 1; return r;
      end
      dx = iabs(px[a] - px[b]);
      dy = iabs(py[a] - py[b]);
      if (dx + dy == 0) begin r.pass = 0; r.code = 3'd4; r.idx = e; r.cyc = t + 1; return r; end
      t += 1;
      r.cost  += dx + dy - 1;
      r.cost1 += (dx + 1) / 2 + (dy + 1) / 2 - 1;
    end
    r.cyc = t + 1;
    return r;
  endfunction

  task automatic set_legal();
    int c;
    for (int i = 0; i < CELLS; i++) grid[i] = -1;
    for (int v = 0; v < NN; v++) begin px[v] = -1; py[v] = -1; end
    for (int v = 0; v < 30; v++) begin
      c = (v * 7) % CELLS;
      grid[c] = v; px[v] = c / N; py[v] = c % N;
    end
    for (int k = 0; k < NE; k++) begin ea[k] = k % 30; eb[k] = (k * 11 + 3) % 30; end
  endtask

  // Node v on cell v, nodes 1 and 23 swapped; edge 0 spans (0,0)-(3,5), rest adjacent.
  task automatic set_far();
    int c;
    for (int v = 0; v < NN; v++) begin
      c = (v == 1) ? 23 : (v == 23) ? 1 : v;
      grid[c] = v; px[v] = c / N; py[v] = c % N;
    end
    ea[0] = 0; eb[0] = 1;
    for (int k = 1; k <= 30; k++) begin ea[k] = grid[k - 1]; eb[k] = grid[k + 5]; end
    ea[31] = grid[30]; eb[31] = grid[31];
  endtask

  task automatic do_start();
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
  endtask

  task automatic wait_done(input int c0, output int cyc, output bit to);
    cyc = c0;
    while (!bus.done && cyc < 3000) begin @(negedge clk); cyc++; end
    to = !bus.done;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++; if ({bus.busy, bus.done, bus.pass, bus.err_code} !== 6'b0) begin n_bad++; $display("FAIL reset_flags: got %b expected 000000", {bus.busy, bus.done, bus.pass, bus.err_code}); end
    n_cmp++; if ({bus.cost, bus.cost_1hop, bus.err_idx} !== 96'b0) begin n_bad++; $display("FAIL reset_values: got cost=%0d c1=%0d idx=%0d expected 0", bus.cost, bus.cost_1hop, bus.err_idx); end
    n_cmp++; if ({bus.reGrid, bus.reEA, bus.reEB, bus.rePX, bus.rePY} !== 5'b0 || bus.addrGrid !== 0 || bus.addrPX !== 0) begin n_bad++; $display("FAIL reset_ports: got re=%b expected 00000", {bus.reGrid, bus.reEA, bus.reEB, bus.rePX, bus.rePY}); end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b expected 0", bus.busy); end
  endtask

  task automatic test_legal();
    exp_t ex; int cyc; bit to;
    set_legal(); sb.push_back(model());
    do_start();
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL legal_busy: got %b expected 1", bus.busy); end
    wait_done(1, cyc, to); ex = sb.pop_front();
    n_cmp++; if (to) begin n_bad++; $display("FAIL legal_timeout: got no done expected done"); end
    n_cmp++; if (cyc !== ex.cyc) begin n_bad++; $display("FAIL legal_latency: got %0d expected %0d", cyc, ex.cyc); end
    n_cmp++; if (bus.pass !== 1'b1 || bus.err_code !== 3'd0) begin n_bad++; $display("FAIL legal_status: got pass=%b code=%0d expected 1/0", bus.pass, bus.err_code); end
    n_cmp++; if (bus.cost !== ex.cost) begin n_bad++; $display("FAIL legal_cost: got %0d expected %0d", bus.cost, ex.cost); end
    n_cmp++; if (bus.cost_1hop !== ex.cost1) begin n_bad++; $display("FAIL legal_cost1: got %0d expected %0d", bus.cost_1hop, ex.cost1); end
    @(negedge clk);
    n_cmp++; if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.pass !== 1'b1) begin n_bad++; $display("FAIL legal_after: got done=%b busy=%b pass=%b expected 0/0/1", bus.done, bus.busy, bus.pass); end
  endtask

  task automatic test_far_edge();
    exp_t ex; int cyc; bit to;
    set_far(); sb.push_back(model());
    do_start(); wait_done(1, cyc, to); ex = sb.pop_front();
    n_cmp++; if (to || cyc !== ex.cyc) begin n_bad++; $display("FAIL far_latency: got %0d (timeout=%b) expected %0d", cyc, to, ex.cyc); end
    n_cmp++; if (bus.pass !== 1'b1 || bus.err_code !== 3'd0) begin n_bad++; $display("FAIL far_status: got pass=%b code=%0d expected 1/0", bus.pass, bus.err_code); end
    n_cmp++; if (bus.cost !== 7) begin n_bad++; $display("FAIL far_cost: got %0d expected 7", bus.cost); end
    n_cmp++; if (bus.cost_1hop !== ex.cost1) begin n_bad++; $display("FAIL far_cost1: got %0d expected %0d", bus.cost_1hop, ex.cost1); end
  endtask

  task automatic test_pos_error();
    exp_t ex; int cyc; bit to;
    set_far();
    grid[9] = -1; grid[14] = 9; px[9] = 3; py[9] = 1;
    sb.push_back(model());
    do_start(); wait_done(1, cyc, to); ex = sb.pop_front();
    n_cmp++; if (to || cyc !== ex.cyc) begin n_bad++; $display("FAIL pos_latency: got %0d (timeout=%b) expected %0d", cyc, to, ex.cyc); end
    n_cmp++; if (bus.pass !== ex.pass || bus.err_code !== ex.code) begin n_bad++; $display("FAIL pos_code: got pass=%b code=%0d expected %b/%0d", bus.pass, bus.err_code, ex.pass, ex.code); end
    n_cmp++; if (bus.err_idx !== ex.idx) begin n_bad++; $display("FAIL pos_idx: got %0d expected %0d", bus.err_idx, ex.idx); end
  endtask

  task automatic test_unplaced();
    exp_t ex; int cyc; bit to;
    set_legal();
    grid[(eb[5] * 7) % CELLS] = -1; px[eb[5]] = -1;
    sb.push_back(model());
    do_start(); wait_done(1, cyc, to); ex = sb.pop_front();
    n_cmp++; if (to || cyc !== ex.cyc) begin n_bad++; $display("FAIL unpl_latency: got %0d (timeout=%b) expected %0d", cyc, to, ex.cyc); end
    n_cmp++; if (bus.pass !== ex.pass || bus.err_code !== ex.code) begin n_bad++; $display("FAIL unpl_code: got pass=%b code=%0d expected %b/%0d", bus.pass, bus.err_code, ex.pass, ex.code); end
    n_cmp++; if (bus.err_idx !== ex.idx) begin n_bad++; $display("FAIL unpl_idx: got %0d expected %0d", bus.err_idx, ex.idx); end
  endtask

  task automatic test_reset_abort();
    exp_t ex; int cyc; bit to; bit seen;
    set_legal();
    do_start();
    cyc = 1; seen = bus.done;
    while (cyc < 20) begin @(negedge clk); cyc++; if (bus.done) seen = 1'b1; end
    n_cmp++; if (bus.busy !== 1'b1 || seen) begin n_bad++; $display("FAIL abort_prior: got busy=%b done_seen=%b expected 1/0", bus.busy, seen); end
    reset = 1'b0;
    #1;
    n_cmp++; if ({bus.busy, bus.done, bus.pass, bus.err_code, bus.reGrid, bus.rePX, bus.rePY} !== 9'b0 || bus.addrGrid !== 0 || bus.cost !== 0) begin n_bad++; $display("FAIL abort_clear: got busy=%b done=%b reGrid=%b addrGrid=%0d expected zeros", bus.busy, bus.done, bus.reGrid, bus.addrGrid); end
    @(negedge clk); reset = 1'b1;
    sb.push_back(model());
    do_start(); wait_done(1, cyc, to); ex = sb.pop_front();
    n_cmp++; if (to || cyc !== ex.cyc) begin n_bad++; $display("FAIL rerun_latency: got %0d (timeout=%b) expected %0d", cyc, to, ex.cyc); end
    n_cmp++; if (bus.pass !== 1'b1 || bus.cost !== ex.cost || bus.cost_1hop !== ex.cost1) begin n_bad++; $display("FAIL rerun_result: got pass=%b cost=%0d c1=%0d expected 1/%0d/%0d", bus.pass, bus.cost, bus.cost_1hop, ex.cost, ex.cost1); end
  endtask

  task automatic test_ignored_start();
    exp_t ex; int cyc; bit to; bit extra;
    set_far(); sb.push_back(model());
    do_start();
    cyc = 1;
    repeat (9) begin @(negedge clk); cyc++; end
    bus.start = 1'b1; @(negedge clk); cyc++; bus.start = 1'b0;
    wait_done(cyc, cyc, to); ex = sb.pop_front();
    n_cmp++; if (to || cyc !== ex.cyc) begin n_bad++; $display("FAIL ign_latency: got %0d (timeout=%b) expected %0d", cyc, to, ex.cyc); end
    bus.start = 1'b1; @(negedge clk); bus.start = 1'b0;
    n_cmp++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_bad++; $display("FAIL ign_done_start: got busy=%b done=%b expected 0/0", bus.busy, bus.done); end
    extra = 1'b0;
    repeat (6) begin @(negedge clk); if (bus.busy || bus.done) extra = 1'b1; end
    n_cmp++; if (extra) begin n_bad++; $display("FAIL ign_restart: got activity expected idle"); end
    n_cmp++; if (bus.pass !== 1'b1 || bus.cost !== ex.cost || bus.cost_1hop !== ex.cost1) begin n_bad++; $display("FAIL ign_hold: got pass=%b cost=%0d c1=%0d expected 1/%0d/%0d", bus.pass, bus.cost, bus.cost_1hop, ex.cost, ex.cost1); end
  endtask

  initial begin
    bus.start = 1'b0;
    test_reset();
    test_legal();
    test_far_edge();
    test_pos_error();
    test_unplaced();
    test_reset_abort();
    test_ignored_start();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
